psk_symbol_mixer: RTL and testbench
===================================

# psk_symbol_mixer

Parametrised BPSK symbol mixer for the TX chain, between the bit source and the DAC sample path. Takes a signed carrier sample stream (one sample per `clk`) and a ready/valid bit stream. Generates its own symbol timing from a clock divider, buffers one bit, and applies each phase reversal only when the carrier is near a zero crossing. Adds an optional differential-encoding mode and underrun reporting.

## Interface
Parameters:
- `DATA_W`, 8: carrier and output sample width, signed two's complement.
- `SYM_DIV`, 833: `clk` cycles per symbol (2 MHz / 2400 baud); must be ≥ 2.
- `ZC_THRESH`, 2: a sample with |sine| ≤ `ZC_THRESH` counts as a zero crossing.
- `DIFF_EN`, 0: 0 = absolute mapping (bit 1 → +1, bit 0 → −1); 1 = differential (bit 1 toggles sign, bit 0 holds it).

Ports:
- `clk` in 1: sample clock, 2 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `mod_ena` in 1: modulation enable, level-sensitive.
- `bit_valid` in 1: source presents `bit_data`.
- `bit_data` in 1: data bit.
- `bit_ready` out 1: holding register empty. A transfer happens when `bit_valid & bit_ready`.
- `sine` in `DATA_W`, signed: carrier sample.
- `bpsk` out `DATA_W`, signed: modulated sample.
- `ena_mod` out 1: registered copy of the modulation-active state.
- `flip_pending` out 1: a sign change is waiting for a zero crossing.
- `underrun` out 1: one-cycle pulse when a symbol boundary finds no bit buffered.

## Operation
- State machine with three states:
  - IDLE: `mod_ena`=0.
  - RUN: sign settled.
  - ALIGN: sign change pending.
- Transitions:
  - IDLE→RUN when `mod_ena`=1.
  - Any state→IDLE the cycle `mod_ena`=0.
  - RUN→ALIGN on a boundary whose target sign differs from the current sign.
  - ALIGN→RUN on the first zero-crossing sample.
- Symbol counter:
  - Counts 0..`SYM_DIV`−1 in RUN and ALIGN, then wraps.
  - Cleared in IDLE.
  - Count 0 is a symbol boundary, so the first RUN cycle is a boundary.
- Holding register (1 entry):
  - Filled on transfer; `bit_ready` = ~`hold_full`.
  - Loading is allowed in IDLE, so the first bit can be preloaded.
- At a boundary with `hold_full`=1:
  - Consume the bit; `hold_full` clears.
  - Compute the target sign from `DIFF_EN`.
  - Set pending if target ≠ current sign.
- At a boundary with `hold_full`=0:
  - Pulse `underrun`; the target sign equals the current sign.
- In ALIGN:
  - Current sign is updated to the target on the first cycle where |sine| ≤ `ZC_THRESH`.
  - That same sample is already output with the new sign.
- A boundary arriving while still in ALIGN (no crossing in a whole symbol):
  - The new target overwrites the old.
  - If the new target equals the current sign, return to RUN.
- Output:
  - `bpsk` = sine when sign=+1.
  - `bpsk` = −sine when sign=−1, saturated: −(−2^(`DATA_W`−1)) → 2^(`DATA_W`−1)−1.
  - `bpsk` = 0 in IDLE.
- Leaving IDLE retains the current sign and the holding register. Pending and the counter are cleared.

## Timing
- Reset values:
  - `bpsk`=0, `ena_mod`=0, `flip_pending`=0, `underrun`=0.
  - Sign=+1, `hold_full`=0, so `bit_ready`=1.
  - State IDLE, counter 0.
- `bpsk`, `ena_mod`, `flip_pending` and `underrun` are registered: one cycle of latency from `sine`/`mod_ena`.
- `bit_ready` is combinational from the `hold_full` flop. No same-cycle refill: a bit consumed at a boundary frees the register on the next cycle.
- A transfer and a boundary in the same cycle: the boundary sees the old `hold_full`, and the new bit is taken after.
- `flip_pending` is high from the cycle after the boundary through the cycle of the zero-crossing sample output.
- `rst` during operation: all outputs are forced to reset values immediately (asynchronously), and any buffered bit is discarded.

## Test plan
- Reset, preload bit 0, `mod_ena`=1, `sine` = ramp through 0 → boundary at cycle 0, `flip_pending` goes 1. The first sample with |sine| ≤ 2 is output negated, then `flip_pending`=0.
- `DIFF_EN`=0, bits 1,1,0,0,1 fed continuously, `SYM_DIV`=8 → sign changes only at boundaries 3 and 5, each at a zero crossing; no `underrun`.
- `DIFF_EN`=1, bits 1,0,1 → sign sequence −1, −1, +1.
- No bit supplied at the second boundary → `underrun` is a one-cycle pulse and the sign holds.
- `sine`=−128, sign=−1, `DATA_W`=8 → `bpsk`=+127.
- `mod_ena` dropped mid-ALIGN → `bpsk`=0 and `flip_pending`=0 the next cycle. On re-enable the counter restarts at 0, and the buffered bit is consumed at the first cycle.

Source files
------------

// File: rtl/psk_symbol_mixer.sv
// BPSK symbol mixer: divides clk into symbols, buffers one bit, and reverses the
// carrier sign only on a near-zero sample so the output never jumps.
module psk_symbol_mixer #(
   parameter int DATA_W    = 8,
   parameter int SYM_DIV   = 833,
   parameter int ZC_THRESH = 2,
   parameter int DIFF_EN   = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mod_ena,
   input  logic                     bit_valid,
   input  logic                     bit_data,
   output logic                     bit_ready,
   input  logic signed [DATA_W-1:0] sine,
   output logic signed [DATA_W-1:0] bpsk,
   output logic                     ena_mod,
   output logic                     flip_pending,
   output logic                     underrun
);

   localparam int CNT_W = (SYM_DIV > 2) ? $clog2(SYM_DIV) : 1;
   localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(SYM_DIV - 1);
   localparam logic [DATA_W:0]          ZC_MAG   = (DATA_W + 1)'(ZC_THRESH);
   localparam logic signed [DATA_W-1:0] S_MAX    = {1'b0, {(DATA_W - 1){1'b1}}};
   localparam logic signed [DATA_W-1:0] S_MIN    = {1'b1, {(DATA_W - 1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      ALIGN
   } state_t;

   state_t                     state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic                       hold_full_q, hold_full_d;
   logic                       hold_bit_q, hold_bit_d;
   logic                       sign_neg_q, sign_neg_d;
   logic                       tgt_neg_q, tgt_neg_d;
   logic signed [DATA_W-1:0]   bpsk_q, bpsk_d;
   logic                       ena_mod_q, ena_mod_d;
   logic                       flip_pending_q, flip_pending_d;
   logic                       underrun_q, underrun_d;

   logic                       boundary;
   logic                       consume;
   logic                       load;
   logic                       near_zero;
   logic                       new_tgt_neg;
   logic [DATA_W:0]            sine_ext;
   logic [DATA_W:0]            sine_mag;
   logic signed [DATA_W-1:0]   neg_sine;

   // Magnitude is one bit wider so the most negative sample does not wrap.
   assign sine_ext  = {sine[DATA_W-1], sine};
   assign sine_mag  = sine[DATA_W-1] ? (~sine_ext + 1'b1) : sine_ext;
   assign near_zero = (sine_mag <= ZC_MAG);
   assign neg_sine  = (sine == S_MIN) ? S_MAX : -sine;

   assign boundary  = mod_ena & (cnt_q == '0);
   assign consume   = boundary & hold_full_q;
   assign load      = bit_valid & ~hold_full_q;

   // NOTE: every signal written here gets a default first, otherwise a path that
   // skips an assignment infers a latch.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      hold_full_d    = hold_full_q;
      hold_bit_d     = hold_bit_q;
      sign_neg_d     = sign_neg_q;
      tgt_neg_d      = tgt_neg_q;
      new_tgt_neg    = sign_neg_q;
      bpsk_d         = '0;
      ena_mod_d      = 1'b0;
      flip_pending_d = 1'b0;
      underrun_d     = 1'b0;

      if (!mod_ena) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         ena_mod_d = 1'b1;
         cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
         if (boundary) begin
            if (hold_full_q) begin
               new_tgt_neg = (DIFF_EN != 0) ? (sign_neg_q ^ hold_bit_q) : ~hold_bit_q;
            end else begin
               underrun_d = 1'b1;
            end
            tgt_neg_d = new_tgt_neg;
            state_d   = (new_tgt_neg != sign_neg_q) ? ALIGN : RUN;
         end else if (state_q == ALIGN && near_zero) begin
            sign_neg_d = tgt_neg_q;
            state_d    = RUN;
         end else if (state_q == IDLE) begin
            state_d = RUN;
         end
         // Stays high through the output cycle of the crossing sample itself.
         flip_pending_d = (state_q == ALIGN) || (state_d == ALIGN);
         bpsk_d         = sign_neg_d ? neg_sine : sine;
      end

      // A boundary only consumes when full and a load only fills when empty,
      // so the two never coincide; a freed register refills next cycle.
      if (consume) begin
         hold_full_d = 1'b0;
      end
      if (load) begin
         hold_full_d = 1'b1;
         hold_bit_d  = bit_data;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         hold_full_q    <= 1'b0;
         hold_bit_q     <= 1'b0;
         sign_neg_q     <= 1'b0;
         tgt_neg_q      <= 1'b0;
         bpsk_q         <= '0;
         ena_mod_q      <= 1'b0;
         flip_pending_q <= 1'b0;
         underrun_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         hold_full_q    <= hold_full_d;
         hold_bit_q     <= hold_bit_d;
         sign_neg_q     <= sign_neg_d;
         tgt_neg_q      <= tgt_neg_d;
         bpsk_q         <= bpsk_d;
         ena_mod_q      <= ena_mod_d;
         flip_pending_q <= flip_pending_d;
         underrun_q     <= underrun_d;
      end
   end

   assign bit_ready    = ~hold_full_q;
   assign bpsk         = bpsk_q;
   assign ena_mod      = ena_mod_q;
   assign flip_pending = flip_pending_q;
   assign underrun     = underrun_q;

endmodule

// File: tb/tb_psk_symbol_mixer.sv
// Bench for psk_symbol_mixer: an absolute-mapping and a differential instance
// share stimulus and are compared against a sign/queue model every cycle.
module tb_psk_symbol_mixer;

   localparam int DW  = 8;
   localparam int DIV = 8;
   localparam int ZC  = 2;

   logic clk;
   logic rst;
   logic mod_ena;
   logic bit_valid;
   logic bit_data;
   logic signed [DW-1:0] sine;

   logic                 bit_ready0, bit_ready1;
   logic signed [DW-1:0] bpsk0, bpsk1;
   logic                 ena_mod0, ena_mod1;
   logic                 fp0, fp1;
   logic                 ur0, ur1;

   int n_pass;
   int n_total;

   psk_symbol_mixer #(.DATA_W(DW), .SYM_DIV(DIV), .ZC_THRESH(ZC), .DIFF_EN(0)) u_abs (
      .clk(clk), .rst(rst), .mod_ena(mod_ena), .bit_valid(bit_valid), .bit_data(bit_data),
      .bit_ready(bit_ready0), .sine(sine), .bpsk(bpsk0), .ena_mod(ena_mod0),
      .flip_pending(fp0), .underrun(ur0)
   );

   psk_symbol_mixer #(.DATA_W(DW), .SYM_DIV(DIV), .ZC_THRESH(ZC), .DIFF_EN(1)) u_diff (
      .clk(clk), .rst(rst), .mod_ena(mod_ena), .bit_valid(bit_valid), .bit_data(bit_data),
      .bit_ready(bit_ready1), .sine(sine), .bpsk(bpsk1), .ena_mod(ena_mod1),
      .flip_pending(fp1), .underrun(ur1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: index 0 = absolute mapping, 1 = differential.
   int m_count;
   bit m_hold[$];
   int m_sign[2];
   int m_tgt[2];
   bit m_pend[2];
   int e_bpsk[2];
   bit e_fp[2];
   bit e_ur;
   bit e_ena;

   task automatic check(input string name, input integer act, input integer exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic model_reset();
      m_count = 0;
      m_hold.delete();
      for (int d = 0; d < 2; d++) begin
         m_sign[d] = 1;
         m_tgt[d]  = 1;
         m_pend[d] = 1'b0;
         e_bpsk[d] = 0;
         e_fp[d]   = 1'b0;
      end
      e_ur  = 1'b0;
      e_ena = 1'b0;
   endtask

   task automatic model_step(input bit en, input bit vld, input bit dat, input int sn);
      bit have;
      bit b;
      bit was;
      bit bnd;
      int tgt;
      int v;
      int mag;
      have = (m_hold.size() != 0);
      b    = 1'b0;
      mag  = (sn < 0) ? -sn : sn;
      if (en) begin
         bnd = (m_count == 0);
         if (bnd && have) b = m_hold.pop_front();
         for (int d = 0; d < 2; d++) begin
            was = m_pend[d];
            if (bnd) begin
               if (!have)       tgt = m_sign[d];
               else if (d == 1) tgt = b ? -m_sign[d] : m_sign[d];
               else             tgt = b ? 1 : -1;
               m_tgt[d]  = tgt;
               m_pend[d] = (tgt != m_sign[d]);
            end else if (m_pend[d] && mag <= ZC) begin
               m_sign[d] = m_tgt[d];
               m_pend[d] = 1'b0;
            end
            v = sn * m_sign[d];
            if (v > 127) v = 127;
            e_bpsk[d] = v;
            e_fp[d]   = was || m_pend[d];
         end
         e_ur    = bnd && !have;
         e_ena   = 1'b1;
         m_count = (m_count + 1) % DIV;
      end else begin
         m_count = 0;
         for (int d = 0; d < 2; d++) begin
            m_pend[d] = 1'b0;
            e_bpsk[d] = 0;
            e_fp[d]   = 1'b0;
         end
         e_ur  = 1'b0;
         e_ena = 1'b0;
      end
      if (vld && !have) m_hold.push_back(dat);
   endtask

   // One clock: drive inputs, check ready before the edge, check outputs after.
   task automatic cycle(input bit en, input bit vld, input bit dat, input int sn);
      mod_ena   = en;
      bit_valid = vld;
      bit_data  = dat;
      sine      = DW'(sn);
      #1;
      check("bit_ready_abs", bit_ready0, m_hold.size() == 0);
      check("bit_ready_diff", bit_ready1, m_hold.size() == 0);
      @(posedge clk);
      model_step(en, vld, dat, sn);
      #1;
      check("bpsk_abs", bpsk0, e_bpsk[0]);
      check("bpsk_diff", bpsk1, e_bpsk[1]);
      check("ena_mod_abs", ena_mod0, e_ena);
      check("ena_mod_diff", ena_mod1, e_ena);
      check("flip_pending_abs", fp0, e_fp[0]);
      check("flip_pending_diff", fp1, e_fp[1]);
      check("underrun_abs", ur0, e_ur);
      check("underrun_diff", ur1, e_ur);
   endtask

   task automatic do_reset();
      mod_ena   = 1'b0;
      bit_valid = 1'b0;
      bit_data  = 1'b0;
      sine      = '0;
      rst       = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   // Feeds a bit list continuously while enabled; returns flip/underrun counts.
   task automatic run_bits(input bit bits[$], input int n_cyc,
                           output int rise0, output int rise1, output int n_ur,
                           output int b0_last, output int b1_last);
      int wave[8] = '{0, 40, 80, 40, 0, -40, -80, -40};
      bit q[$];
      bit take;
      bit p0, p1;
      q = bits;
      rise0 = 0; rise1 = 0; n_ur = 0; p0 = 1'b0; p1 = 1'b0;
      take = (m_hold.size() == 0);
      cycle(1'b0, 1'b1, q[0], 0);
      if (take) void'(q.pop_front());
      for (int i = 0; i < n_cyc; i++) begin
         take = (q.size() > 0) && (m_hold.size() == 0);
         cycle(1'b1, q.size() > 0, (q.size() > 0) ? q[0] : 1'b0, wave[i % 8]);
         if (take) void'(q.pop_front());
         if (fp0 && !p0) rise0++;
         if (fp1 && !p1) rise1++;
         if (ur0) n_ur++;
         p0 = fp0;
         p1 = fp1;
         if (i % 8 == 7) begin
            b0_last = bpsk0;
            b1_last = bpsk1;
            if (bits.size() == 3) begin
               check("diff_symbol_sign", bpsk1, (i == 23) ? -40 : 40);
            end
         end
      end
   endtask

   typedef struct {
      int sn;
      int exp0;
      int exp1;
   } vec_t;

   initial begin
      vec_t vec[6];
      bit   bits_c[$];
      bit   bits_d[$];
      int   r0, r1, nu, b0, b1;

      vec[0] = '{-128, 127, -128};
      vec[1] = '{127, -127, 127};
      vec[2] = '{1, -1, 1};
      vec[3] = '{-1, 1, -1};
      vec[4] = '{0, 0, 0};
      vec[5] = '{100, -100, 100};
      bits_c = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      bits_d = '{1'b1, 1'b0, 1'b1};

      n_pass  = 0;
      n_total = 0;
      rst     = 1'b1;
      model_reset();

      // Reset state.
      do_reset();
      check("rst_bpsk", bpsk0, 0);
      check("rst_ena_mod", ena_mod0, 0);
      check("rst_flip_pending", fp0, 0);
      check("rst_underrun", ur0, 0);
      check("rst_bit_ready", bit_ready0, 1);

      // Preloaded 0, ramp through zero: first near-zero sample comes out negated.
      cycle(1'b0, 1'b1, 1'b0, 0);
      cycle(1'b1, 1'b0, 1'b0, 20);
      check("ramp_pending_set", fp0, 1);
      cycle(1'b1, 1'b0, 1'b0, 14);
      cycle(1'b1, 1'b0, 1'b0, 8);
      cycle(1'b1, 1'b0, 1'b0, 2);
      check("ramp_zc_negated", bpsk0, -2);
      check("ramp_pending_through_zc", fp0, 1);
      check("ramp_diff_holds", bpsk1, 2);
      cycle(1'b1, 1'b0, 1'b0, -4);
      check("ramp_pending_clear", fp0, 0);
      check("ramp_after_zc", bpsk0, 4);

      // Bits 1,1,0,0,1: two absolute flips, three differential flips, no underrun.
      do_reset();
      run_bits(bits_c, 40, r0, r1, nu, b0, b1);
      check("abs_flip_count", r0, 2);
      check("diff_flip_count", r1, 3);
      check("stream_underruns", nu, 0);
      check("abs_final_sign", b0, -40);
      check("diff_final_sign", b1, 40);

      // Differential 1,0,1: signs -1,-1,+1 (checked per symbol inside run_bits).
      do_reset();
      run_bits(bits_d, 24, r0, r1, nu, b0, b1);
      check("diff_101_flips", r1, 2);

      // Missing bit at second boundary: one-cycle underrun, sign holds.
      do_reset();
      cycle(1'b0, 1'b1, 1'b1, 0);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 30);
         if (i == 7) check("underrun_before", ur0, 0);
         if (i == 8) check("underrun_pulse", ur0, 1);
         if (i == 8) check("align_overwrite_pending", fp1, 1);
      end
      check("underrun_after", ur0, 0);
      check("underrun_sign_hold", bpsk0, 30);
      check("align_overwrite_run", fp1, 0);
      check("align_overwrite_sign", bpsk1, 30);

      // Saturated negation table with the absolute sign settled at -1.
      do_reset();
      cycle(1'b0, 1'b1, 1'b0, 0);
      cycle(1'b1, 1'b0, 1'b0, 50);
      cycle(1'b1, 1'b0, 1'b0, 0);
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 1'b0, 1'b0, vec[i].sn);
         check($sformatf("table_abs_%0d", i), bpsk0, vec[i].exp0);
         check($sformatf("table_diff_%0d", i), bpsk1, vec[i].exp1);
      end

      // mod_ena dropped mid-ALIGN, bit preloaded in IDLE, consumed on re-enable.
      do_reset();
      cycle(1'b0, 1'b1, 1'b0, 0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 50);
      check("drop_pending_before", fp0, 1);
      cycle(1'b0, 1'b1, 1'b1, 50);
      check("drop_bpsk_zero", bpsk0, 0);
      check("drop_pending_clear", fp0, 0);
      check("drop_ena_mod", ena_mod0, 0);
      cycle(1'b1, 1'b0, 1'b0, 50);
      check("reenable_no_pending", fp0, 0);
      check("reenable_bpsk", bpsk0, 50);
      check("reenable_consumed", bit_ready0, 1);
      check("reenable_diff_pending", fp1, 1);
      check("reenable_no_underrun", ur0, 0);

      // Asynchronous reset mid-cycle discards the buffered bit.
      do_reset();
      cycle(1'b0, 1'b1, 1'b1, 0);
      cycle(1'b1, 1'b0, 1'b0, 60);
      cycle(1'b1, 1'b1, 1'b0, 60);
      check("pre_async_full", bit_ready0, 0);
      rst = 1'b1;
      #2;
      check("async_bpsk", bpsk0, 0);
      check("async_ena_mod", ena_mod0, 0);
      check("async_bit_ready", bit_ready0, 1);
      check("async_flip_pending", fp0, 0);
      check("async_underrun", ur0, 0);
      do_reset();

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         int sn;
         if ($urandom_range(0, 3) == 0) sn = int'($urandom_range(0, 6)) - 3;
         else                           sn = int'($urandom_range(0, 255)) - 128;
         cycle($urandom_range(0, 99) < 95, $urandom_range(0, 2) == 0,
               1'($urandom_range(0, 1)), sn);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
